// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_pkg
//  Description : Shared types, default parameters and the priority encoder
//                for the interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
package int_pkg;

    localparam int              NIRQ_DEF        = 4;
    localparam int              PC_W_DEF        = 10;
    localparam int              ID_W            = 2;
    localparam logic [9:0]      VEC_BASE_DEF    = 10'h3F0;
    localparam int              VEC_STRIDE_DEF  = 4;
    localparam int              SYNC_STAGES_DEF = 2;

    // 2'd3 is not a member; the FSM default branch returns it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Index of the lowest set bit (0 = highest priority); 0 when none set.
    function automatic logic [ID_W-1:0] prio_enc(input logic [31:0] v);
        prio_enc = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) prio_enc = ID_W'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Control-unit / datapath side bundle of the interrupt
//                controller. slave = controller, master = control unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface int_ctrl_if
    import int_pkg::*;
#(
    parameter int NIRQ = NIRQ_DEF,
    parameter int PC_W = PC_W_DEF
) ();

    logic [NIRQ-1:0] irq_in;
    logic            boundary;
    logic            reti;
    logic            ei;
    logic            di;
    logic            we_mask;
    logic [NIRQ-1:0] mask_in;
    logic [NIRQ-1:0] clr_pend;

    logic            take;
    logic [PC_W-1:0] vec_addr;
    logic [ID_W-1:0] irq_id;
    logic            in_service;
    logic [NIRQ-1:0] pending;
    logic            gie_out;

    modport slave (
        input  irq_in, boundary, reti, ei, di, we_mask, mask_in, clr_pend,
        output take, vec_addr, irq_id, in_service, pending, gie_out
    );

    modport master (
        output irq_in, boundary, reti, ei, di, we_mask, mask_in, clr_pend,
        input  take, vec_addr, irq_id, in_service, pending, gie_out
    );

endinterface
`default_nettype wire

// File: rtl/int_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchroniser for one asynchronous request line,
//                followed by a last-value flop giving a 1-cycle rise pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;

    // Shift the raw input in at bit 0; the top bit is the synchronised value.
    always_comb begin
        sync_d = SYNC_STAGES'({sync_q, d});
        last_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and last-value registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Prioritised, maskable, non-nesting interrupt controller that
//                sequences interrupt entry at an instruction boundary and
//                blocks further entries until return-from-interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module int_ctrl
    import int_pkg::*;
#(
    parameter int              NIRQ        = NIRQ_DEF,
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] VEC_BASE    = PC_W'(VEC_BASE_DEF),
    parameter int              VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter int              SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  wire logic  clk,
    input  wire logic  reset,
    int_ctrl_if.slave  bus
);

    state_t          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic            gie_q, gie_d;

    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] sel;
    logic [ID_W-1:0] sel_id;
    logic [NIRQ-1:0] take_clr;
    logic            accept;
    logic            svc_ret;
    logic [PC_W-1:0] vec;

    generate
        for (genvar i = 0; i < NIRQ; i++) begin : g_sync
            sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (bus.irq_in[i]),
                .rise  (irq_edge[i])
            );
        end
    endgenerate

    assign sel     = pending_q & mask_q;
    assign sel_id  = prio_enc(32'(sel));
    assign svc_ret = (state_q == ST_SERVICE) && bus.reti;
    assign vec     = PC_W'(32'(VEC_BASE) + 32'(id_q) * 32'(VEC_STRIDE));

    // FSM next state: accept a request only in IDLE at a boundary with gie set.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && (|sel) && bus.boundary) begin
                    accept  = 1'b1;
                    id_d    = sel_id;
                    state_d = ST_TAKE;
                end
            end
            ST_TAKE:    state_d = ST_SERVICE;
            ST_SERVICE: if (bus.reti) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pending / mask / gie next values; a fresh edge overrides any clear.
    always_comb begin
        take_clr = '0;
        if (accept) take_clr[sel_id] = 1'b1;
        pending_d = irq_edge | (pending_q & ~bus.clr_pend & ~take_clr);
        mask_d    = bus.we_mask ? bus.mask_in : mask_q;
        gie_d     = gie_q;
        if (bus.ei) gie_d = 1'b1;
        if (bus.di) gie_d = 1'b0;
        if (svc_ret) gie_d = 1'b1;
        if (accept)  gie_d = 1'b0;
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
        end
    end

    assign bus.take       = (state_q == ST_TAKE);
    assign bus.vec_addr   = (state_q == ST_TAKE) ? vec : '0;
    assign bus.irq_id     = ((state_q == ST_TAKE) || (state_q == ST_SERVICE)) ? id_q : '0;
    assign bus.in_service = (state_q == ST_SERVICE);
    assign bus.pending    = pending_q;
    assign bus.gie_out    = gie_q;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Directed self-checking bench for int_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    int_ctrl_if #(.NIRQ(4), .PC_W(10)) bus ();

    int_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.irq_in   = '0;
        bus.boundary = 1'b0;
        bus.reti     = 1'b0;
        bus.ei       = 1'b0;
        bus.di       = 1'b0;
        bus.we_mask  = 1'b0;
        bus.mask_in  = '0;
        bus.clr_pend = '0;
        step(3);
        check("rst_take",  32'(bus.take),       0);
        check("rst_vec",   32'(bus.vec_addr),   0);
        check("rst_id",    32'(bus.irq_id),     0);
        check("rst_svc",   32'(bus.in_service), 0);
        check("rst_pend",  32'(bus.pending),    0);
        check("rst_gie",   32'(bus.gie_out),    0);
        reset = 1'b1;

        // 1: single request on line 2
        bus.we_mask = 1'b1; bus.mask_in = 4'b0100; bus.ei = 1'b1;
        bus.irq_in = 4'b0100; bus.boundary = 1'b1;
        step(1);
        bus.we_mask = 1'b0; bus.ei = 1'b0;
        check("t1_gie_set", 32'(bus.gie_out), 1);
        step(1);
        check("t1_pend_early", 32'(bus.pending), 0);
        step(1);
        check("t1_pend", 32'(bus.pending), 32'b0100);
        check("t1_notake", 32'(bus.take), 0);
        step(1);
        check("t1_take", 32'(bus.take), 1);
        check("t1_vec",  32'(bus.vec_addr), 32'h3F8);
        check("t1_id",   32'(bus.irq_id), 2);
        check("t1_gie",  32'(bus.gie_out), 0);
        check("t1_pclr", 32'(bus.pending), 0);
        step(1);
        check("t1_svc",   32'(bus.in_service), 1);
        check("t1_take0", 32'(bus.take), 0);
        check("t1_vec0",  32'(bus.vec_addr), 0);
        check("t1_idh",   32'(bus.irq_id), 2);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        check("t1_ret_svc", 32'(bus.in_service), 0);
        check("t1_ret_gie", 32'(bus.gie_out), 1);

        // 2: simultaneous edges on lines 1 and 3
        bus.irq_in = 4'b1010; bus.we_mask = 1'b1; bus.mask_in = 4'hF;
        step(1);
        bus.we_mask = 1'b0;
        step(2);
        check("t2_pend", 32'(bus.pending), 32'b1010);
        step(1);
        check("t2_take", 32'(bus.take), 1);
        check("t2_vec",  32'(bus.vec_addr), 32'h3F4);
        check("t2_id",   32'(bus.irq_id), 1);
        check("t2_pend_left", 32'(bus.pending), 32'b1000);
        step(1);
        check("t2_svc", 32'(bus.in_service), 1);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        check("t2_ret_take", 32'(bus.take), 0);
        step(1);
        check("t2_take3", 32'(bus.take), 1);
        check("t2_vec3",  32'(bus.vec_addr), 32'h3FC);
        check("t2_id3",   32'(bus.irq_id), 3);
        check("t2_pend0", 32'(bus.pending), 0);
        step(1);

        // 3: higher-priority edge while in service, ei in service
        bus.irq_in = 4'b1011;
        step(3);
        check("t3_pend", 32'(bus.pending), 32'b0001);
        check("t3_nonest", 32'(bus.take), 0);
        check("t3_svc", 32'(bus.in_service), 1);
        bus.ei = 1'b1; step(1); bus.ei = 1'b0;
        check("t3_gie_ei", 32'(bus.gie_out), 1);
        step(2);
        check("t3_nonest2", 32'(bus.take), 0);
        check("t3_id_held", 32'(bus.irq_id), 3);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        check("t3_idle", 32'(bus.in_service), 0);
        step(1);
        check("t3_take0", 32'(bus.take), 1);
        check("t3_vec0",  32'(bus.vec_addr), 32'h3F0);
        check("t3_id0",   32'(bus.irq_id), 0);
        step(1);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;

        // 4: masked request, then unmask; edge beats software clear
        bus.we_mask = 1'b1; bus.mask_in = 4'b0000; bus.irq_in = 4'b0000;
        step(1);
        bus.we_mask = 1'b0;
        step(3);
        bus.irq_in = 4'b0010;
        step(3);
        check("t4_pend", 32'(bus.pending), 32'b0010);
        step(2);
        check("t4_masked", 32'(bus.take), 0);
        check("t4_masked_svc", 32'(bus.in_service), 0);
        bus.we_mask = 1'b1; bus.mask_in = 4'b0010;
        step(1);
        bus.we_mask = 1'b0;
        step(1);
        check("t4_take", 32'(bus.take), 1);
        check("t4_id",   32'(bus.irq_id), 1);
        check("t4_vec",  32'(bus.vec_addr), 32'h3F4);
        step(1);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        bus.boundary = 1'b0; bus.irq_in = 4'b0000;
        step(3);
        bus.irq_in = 4'b0010;
        step(2);
        bus.clr_pend = 4'b0010;
        step(1);
        bus.clr_pend = 4'b0000;
        check("t4_edge_beats_clr", 32'(bus.pending), 32'b0010);
        step(2);
        check("t4_bnd_hold", 32'(bus.take), 0);
        bus.clr_pend = 4'b0010; step(1); bus.clr_pend = 4'b0000;
        check("t4_clr", 32'(bus.pending), 0);

        // 5: level held high is one request; reset during TAKE
        bus.we_mask = 1'b1; bus.mask_in = 4'b0000; bus.irq_in = 4'b0000;
        step(1);
        bus.we_mask = 1'b0;
        step(3);
        bus.irq_in = 4'b0100;
        step(20);
        check("t5_level_pend", 32'(bus.pending), 32'b0100);
        bus.clr_pend = 4'b0100; step(1); bus.clr_pend = 4'b0000;
        step(5);
        check("t5_level_once", 32'(bus.pending), 0);
        bus.irq_in = 4'b0000;
        step(3);
        bus.we_mask = 1'b1; bus.mask_in = 4'hF;
        step(1);
        bus.we_mask = 1'b0;
        bus.irq_in = 4'b0001;
        step(5);
        check("t5_pend0", 32'(bus.pending), 32'b0001);
        check("t5_bnd_hold", 32'(bus.take), 0);
        bus.boundary = 1'b1;
        step(1);
        check("t5_take", 32'(bus.take), 1);
        reset = 1'b0; bus.irq_in = 4'b0000;
        #1;
        check("t5_rst_take", 32'(bus.take),       0);
        check("t5_rst_vec",  32'(bus.vec_addr),   0);
        check("t5_rst_id",   32'(bus.irq_id),     0);
        check("t5_rst_svc",  32'(bus.in_service), 0);
        check("t5_rst_pend", 32'(bus.pending),    0);
        check("t5_rst_gie",  32'(bus.gie_out),    0);
        step(1);
        reset = 1'b1;
        step(2);
        check("t5_post_take", 32'(bus.take), 0);
        check("t5_post_svc",  32'(bus.in_service), 0);

        // 6: ei/di collision and reti in IDLE
        bus.ei = 1'b1; bus.di = 1'b1; step(1); bus.ei = 1'b0; bus.di = 1'b0;
        check("t6_di_wins", 32'(bus.gie_out), 0);
        bus.ei = 1'b1; step(1); bus.ei = 1'b0;
        check("t6_ei", 32'(bus.gie_out), 1);
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        check("t6_reti_gie1", 32'(bus.gie_out), 1);
        check("t6_reti_svc",  32'(bus.in_service), 0);
        check("t6_reti_take", 32'(bus.take), 0);
        bus.di = 1'b1; step(1); bus.di = 1'b0;
        bus.reti = 1'b1; step(1); bus.reti = 1'b0;
        check("t6_reti_gie0", 32'(bus.gie_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
